// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage: bus layouts,
// stall-vector bit positions, load-type encoding and read-buffer states.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 76;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_RF_WD = 38;
  localparam int LOAD_BUS_WD  = 5;
  localparam int STALL_BUS_WD = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;

  localparam int LD_LB  = 4;
  localparam int LD_LBU = 3;
  localparam int LD_LH  = 2;
  localparam int LD_LHU = 1;
  localparam int LD_LW  = 0;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } rbuf_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  typedef struct packed {
    logic lb;
    logic lbu;
    logic lh;
    logic lhu;
    logic lw;
  } load_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } rf_wr_t;

  typedef struct packed {
    logic [31:0] pc;
    rf_wr_t      rf;
  } mem_to_wb_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Extracts and extends the loaded byte/halfword/word from a read word and
// flags misaligned halfword/word loads.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  load_t       load,
  output logic [31:0] ext_data,
  output logic        adel
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    byte_v   = rdata[{addr, 3'b000} +: 8];
    half_v   = addr[1] ? rdata[31:16] : rdata[15:0];
    ext_data = '0;
    if (load.lb)       ext_data = {{24{byte_v[7]}}, byte_v};
    else if (load.lbu) ext_data = {24'h0, byte_v};
    else if (load.lh)  ext_data = {{16{half_v[15]}}, half_v};
    else if (load.lhu) ext_data = {16'h0, half_v};
    else if (load.lw)  ext_data = rdata;
    adel = ((load.lh | load.lhu) & addr[0]) | (load.lw & (addr != 2'b00));
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute results, buffers the
// SRAM read return across stalls and drives the write-back/forwarding buses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [STALL_BUS_WD-1:0] stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [LOAD_BUS_WD-1:0]  ex_load_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
  output logic                    mem_adel
);

  ex_to_mem_t  mem_bus_q, mem_bus_d;
  load_t       load_q, load_d;
  rbuf_state_e state_q, state_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;

  logic [31:0] rdata_eff;
  logic [31:0] ext_data;
  logic        adel;
  rf_wr_t      rf_wr;
  mem_to_wb_t  wb;

  always_comb begin
    mem_bus_d = mem_bus_q;
    load_d    = load_q;
    if (stall[STALL_MEM] == NO_STOP) begin
      mem_bus_d = ex_to_mem_bus;
      load_d    = ex_load_bus;
    end else if (stall[STALL_WB] == NO_STOP) begin
      mem_bus_d = '0;
      load_d    = '0;
    end
  end

  // The SRAM returns data only in the cycle after the request; a stall on
  // that edge must latch it, and the buffer serves it until the stall clears.
  always_comb begin
    state_d     = state_q;
    rdata_buf_d = rdata_buf_q;
    case (state_q)
      RUN: begin
        if (stall[STALL_MEM] == STOP) begin
          state_d     = HOLD;
          rdata_buf_d = data_sram_rdata;
        end
      end
      HOLD: begin
        if (stall[STALL_MEM] == NO_STOP) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_bus_q   <= '0;
      load_q      <= '0;
      state_q     <= RUN;
      rdata_buf_q <= '0;
    end else begin
      mem_bus_q   <= mem_bus_d;
      load_q      <= load_d;
      state_q     <= state_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  assign rdata_eff = (state_q == HOLD) ? rdata_buf_q : data_sram_rdata;

  load_align u_load_align (
    .rdata    (rdata_eff),
    .addr     (mem_bus_q.ex_result[1:0]),
    .load     (load_q),
    .ext_data (ext_data),
    .adel     (adel)
  );

  always_comb begin
    rf_wr.rf_we    = mem_bus_q.rf_we & ~adel;
    rf_wr.rf_waddr = mem_bus_q.rf_waddr;
    rf_wr.rf_wdata = (mem_bus_q.sel_rf_res && (|load_q)) ? ext_data
                                                         : mem_bus_q.ex_result;
    wb.pc          = mem_bus_q.pc;
    wb.rf          = rf_wr;
  end

  assign mem_to_wb_bus = wb;
  assign mem_to_rf_bus = rf_wr;
  assign mem_adel      = adel;

  // SRAM enables were consumed by execute's request; other stall bits belong to other stages.
  logic unused_inputs;
  assign unused_inputs = ^{mem_bus_q.data_ram_en, mem_bus_q.data_ram_wen,
                           stall[STALL_BUS_WD-1], stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of load/non-load vectors plus
// hand-written stall, bubble and reset sequences checked through a scoreboard.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                    clk;
  logic                    resetn;
  logic [STALL_BUS_WD-1:0] stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [LOAD_BUS_WD-1:0]  ex_load_bus;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus;
  logic                    mem_adel;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_load_bus     (ex_load_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_rf_bus   (mem_to_rf_bus),
    .mem_adel        (mem_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] L_NONE = 5'b00000;
  localparam logic [4:0] L_LB   = 5'b10000;
  localparam logic [4:0] L_LBU  = 5'b01000;
  localparam logic [4:0] L_LH   = 5'b00100;
  localparam logic [4:0] L_LHU  = 5'b00010;
  localparam logic [4:0] L_LW   = 5'b00001;

  localparam logic [5:0] ST_RUN    = 6'b000000;
  localparam logic [5:0] ST_HOLD   = 6'b011000;
  localparam logic [5:0] ST_BUBBLE = 6'b001111;

  typedef struct {
    string       name;
    logic [4:0]  ld;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        sel;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] exp_data;
    logic        exp_we;
    logic        exp_adel;
    logic        care_data;
  } vec_t;

  typedef struct {
    string       name;
    logic [69:0] wb;
    logic [69:0] mask;
    logic        adel;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always @(ex_load_bus)
    assert ($onehot0(ex_load_bus)) else $error("illegal load bus %b", ex_load_bus);

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [75:0] mk_ex(input logic [31:0] pc, input logic en, input logic sel,
                                        input logic we, input logic [4:0] wa,
                                        input logic [31:0] res);
    return {pc, en, 4'b0000, sel, we, wa, res};
  endfunction

  function automatic logic [69:0] mk_wb(input logic [31:0] pc, input logic we,
                                        input logic [4:0] wa, input logic [31:0] data);
    return {pc, we, wa, data};
  endfunction

  task automatic expect_out(input string name, input logic [69:0] wb, input logic care,
                            input logic adel);
    exp_t e;
    e.name = name;
    e.wb   = wb;
    e.mask = care ? {70{1'b1}} : {{38{1'b1}}, 32'h0};
    e.adel = adel;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t        e;
    logic [69:0] rf_act;
    logic [69:0] rf_req;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_underflow: got 0 entries expected 1");
      return;
    end
    e      = sb.pop_front();
    rf_act = {32'h0, mem_to_rf_bus} & e.mask;
    rf_req = {32'h0, e.wb[37:0]} & e.mask;
    check({e.name, "_wb"}, mem_to_wb_bus & e.mask, e.wb & e.mask);
    check({e.name, "_rf"}, rf_act, rf_req);
    check({e.name, "_adel"}, {69'h0, mem_adel}, {69'h0, e.adel});
  endtask

  task automatic drive(input logic [4:0] ld, input logic [75:0] ex, input logic [31:0] rd,
                       input logic [5:0] st);
    ex_load_bus     = ld;
    ex_to_mem_bus   = ex;
    data_sram_rdata = rd;
    stall           = st;
  endtask

  task automatic add_vec(input string name, input logic [4:0] ld, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic sel, input logic we,
                         input logic [4:0] waddr, input logic [31:0] exp_data,
                         input logic exp_we, input logic exp_adel, input logic care_data);
    vec_t v;
    v.name = name; v.ld = ld; v.addr = addr; v.rdata = rdata; v.sel = sel; v.we = we;
    v.waddr = waddr; v.exp_data = exp_data; v.exp_we = exp_we; v.exp_adel = exp_adel;
    v.care_data = care_data;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pc;

    add_vec("lb_sx",     L_LB,   32'h1003, 32'h80FF_1234, 1, 1, 5'd8,  32'hFFFF_FF80, 1, 0, 1);
    add_vec("lbu_zx",    L_LBU,  32'h1003, 32'h80FF_1234, 1, 1, 5'd8,  32'h0000_0080, 1, 0, 1);
    add_vec("lh_hi",     L_LH,   32'h1002, 32'h8001_7FFF, 1, 1, 5'd9,  32'hFFFF_8001, 1, 0, 1);
    add_vec("lhu_lo",    L_LHU,  32'h1000, 32'h8001_7FFF, 1, 1, 5'd9,  32'h0000_7FFF, 1, 0, 1);
    add_vec("lhu_hi",    L_LHU,  32'h1002, 32'h8001_7FFF, 1, 1, 5'd9,  32'h0000_8001, 1, 0, 1);
    add_vec("lw_mis",    L_LW,   32'h1002, 32'hDEAD_BEEF, 1, 1, 5'd10, 32'h0,         0, 1, 0);
    add_vec("lw_ok",     L_LW,   32'h1004, 32'hDEAD_BEEF, 1, 1, 5'd10, 32'hDEAD_BEEF, 1, 0, 1);
    add_vec("lh_mis",    L_LH,   32'h1001, 32'h8001_7FFF, 1, 1, 5'd11, 32'h0,         0, 1, 0);
    add_vec("lb_b1",     L_LB,   32'h1001, 32'h80FF_1234, 1, 1, 5'd12, 32'h0000_0012, 1, 0, 1);
    add_vec("lbu_b2",    L_LBU,  32'h0002, 32'h80FF_1234, 1, 1, 5'd12, 32'h0000_00FF, 1, 0, 1);
    add_vec("alu",       L_NONE, 32'h0042, 32'hFFFF_FFFF, 0, 1, 5'd5,  32'h0000_0042, 1, 0, 1);
    add_vec("sel_noload",L_NONE, 32'h1234_5678, 32'hAAAA_AAAA, 1, 1, 5'd6, 32'h1234_5678, 1, 0, 1);
    add_vec("lw_nosel",  L_LW,   32'h1000, 32'hCAFE_F00D, 0, 1, 5'd7,  32'h0000_1000, 1, 0, 1);
    add_vec("alu_nowe",  L_NONE, 32'h0000_0099, 32'h0, 0, 0, 5'd3, 32'h0000_0099, 0, 0, 1);

    resetn = 1'b0;
    drive(L_NONE, '0, 32'h0, ST_RUN);
    #2;
    expect_out("reset", 70'h0, 1, 0);
    pop_check();
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      pc = 32'h0040_0000 + 32'(i * 4);
      drive(vecs[i].ld, mk_ex(pc, vecs[i].ld != 0, vecs[i].sel, vecs[i].we, vecs[i].waddr,
            vecs[i].addr), vecs[i].rdata, ST_RUN);
      expect_out(vecs[i].name, mk_wb(pc, vecs[i].exp_we, vecs[i].waddr, vecs[i].exp_data),
                 vecs[i].care_data, vecs[i].exp_adel);
      @(posedge clk);
      #1 pop_check();
    end

    // Multi-cycle stall keeps the data captured on the first stalled edge.
    @(negedge clk);
    drive(L_LW, mk_ex(32'h0050_0000, 1, 1, 1, 5'd4, 32'h1004), 32'h1111_1111, ST_RUN);
    expect_out("hold_first", mk_wb(32'h0050_0000, 1, 5'd4, 32'h1111_1111), 1, 0);
    @(posedge clk);
    #1 pop_check();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      stall = ST_HOLD;
      expect_out($sformatf("hold_%0d", k), mk_wb(32'h0050_0000, 1, 5'd4, 32'h1111_1111), 1, 0);
      @(posedge clk);
      #1 data_sram_rdata = 32'h2222_2222;
      #1 pop_check();
    end
    @(negedge clk);
    drive(L_LW, mk_ex(32'h0050_0004, 1, 1, 1, 5'd4, 32'h1008), 32'h2222_2222, ST_RUN);
    expect_out("hold_release", mk_wb(32'h0050_0000, 1, 5'd4, 32'h1111_1111), 1, 0);
    #1 pop_check();
    expect_out("run_after_hold", mk_wb(32'h0050_0004, 1, 5'd4, 32'h2222_2222), 1, 0);
    @(posedge clk);
    #1 pop_check();

    // Bubble: this stage stopped, write-back running.
    @(negedge clk);
    drive(L_NONE, mk_ex(32'h0060_0000, 0, 0, 1, 5'd5, 32'h42), 32'h0, ST_RUN);
    expect_out("pre_bubble", mk_wb(32'h0060_0000, 1, 5'd5, 32'h42), 1, 0);
    @(posedge clk);
    #1 pop_check();
    @(negedge clk);
    stall = ST_BUBBLE;
    expect_out("bubble", 70'h0, 1, 0);
    @(posedge clk);
    #1 pop_check();
    @(negedge clk);
    drive(L_LW, mk_ex(32'h0060_0004, 1, 1, 1, 5'd2, 32'h1004), 32'hDEAD_BEEF, ST_RUN);
    expect_out("after_bubble", mk_wb(32'h0060_0004, 1, 5'd2, 32'hDEAD_BEEF), 1, 0);
    @(posedge clk);
    #1 pop_check();

    // Asynchronous reset while holding buffered data.
    @(negedge clk);
    drive(L_LW, mk_ex(32'h0070_0000, 1, 1, 1, 5'd1, 32'h1004), 32'h3333_3333, ST_RUN);
    expect_out("rst_pre", mk_wb(32'h0070_0000, 1, 5'd1, 32'h3333_3333), 1, 0);
    @(posedge clk);
    #1 pop_check();
    @(negedge clk);
    stall = ST_HOLD;
    expect_out("rst_hold", mk_wb(32'h0070_0000, 1, 5'd1, 32'h3333_3333), 1, 0);
    @(posedge clk);
    #1 data_sram_rdata = 32'h4444_4444;
    #1 pop_check();
    #1 resetn = 1'b0;
    expect_out("rst_async", 70'h0, 1, 0);
    #1 pop_check();
    @(negedge clk);
    resetn = 1'b1;
    drive(L_LW, mk_ex(32'h0070_0004, 1, 1, 1, 5'd1, 32'h1004), 32'h5555_5555, ST_RUN);
    expect_out("rst_after", mk_wb(32'h0070_0004, 1, 5'd1, 32'h5555_5555), 1, 0);
    @(posedge clk);
    #1 pop_check();

    check("sb_empty", 70'(sb.size()), 70'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
